// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// Size encodings, ownership state and byte-lane mask computation.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    // An all-zero mask marks a misaligned or illegal access.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b0001 << lo;
            SZ_HALF: if (!lo[0]) m = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: if (lo == 2'b00) m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU-side data-memory bus: request strobes from the memory stage,
// registered load result and misalign strobe back from the controller.
interface dmem_if #(
    parameter int ADDR_W = 14
);
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [ADDR_W+1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              misalign;

    modport master (
        output mem_read, mem_write, mem_size, mem_unsigned, addr, wdata,
        input  rdata, rvalid, misalign
    );

    modport slave (
        input  mem_read, mem_write, mem_size, mem_unsigned, addr, wdata,
        output rdata, rvalid, misalign
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port 32-bit RAM bank with byte write enables.
// Synchronous read-first read.
module dmem_bank #(
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] adr,
  input  logic [3:0]        we,
  input  logic [31:0]       wd,
  output logic [31:0]       rd
);
  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[adr][8*i +: 8] <= wd[8*i +: 8];
    end
    rd <= mem[adr];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: sized stores, extended loads with a
// two-edge response pipeline, and loader/CPU bank ownership.
module dmem_ctrl #(
    parameter int ADDR_W    = 14,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    dmem_if.slave             bus,
    output logic              loading,
    output logic [ADDR_W:0]   load_count,
    input  logic              upg_start_i,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [31:0]       upg_dat_i,
    input  logic              upg_done_i
);
    import dmem_pkg::*;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic              run;
    logic [3:0]        mask;
    logic              mis_c;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [ADDR_W-1:0] bank_adr;
    logic [3:0]        bank_we;
    logic [31:0]       bank_wd;
    logic [31:0]       bank_rd;
    logic [31:0]       wd_al;

    logic              p_rd;
    logic              p_mis;
    logic [1:0]        p_size;
    logic              p_uns;
    logic [1:0]        p_lo;
    logic [31:0]       ext;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              mis_q;

    assign run     = (state == ST_RUN);
    assign loading = (state == ST_LOAD);
    assign mask    = lane_mask(bus.mem_size, bus.addr[1:0]);
    assign mis_c   = (mask == 4'b0000);
    assign cpu_wr  = run & bus.mem_write;
    assign cpu_rd  = run & bus.mem_read & ~bus.mem_write;

    always_comb begin
        wd_al = bus.wdata;
        case (bus.mem_size)
            SZ_BYTE: wd_al = {4{bus.wdata[7:0]}};
            SZ_HALF: wd_al = {2{bus.wdata[15:0]}};
            default: wd_al = bus.wdata;
        endcase
    end

    always_comb begin
        bank_adr = upg_adr_i;
        bank_wd  = upg_dat_i;
        bank_we  = upg_wen_i ? 4'b1111 : 4'b0000;
        if (run) begin
            bank_adr = bus.addr[ADDR_W+1:2];
            bank_wd  = wd_al;
            bank_we  = (cpu_wr && !mis_c) ? mask : 4'b0000;
        end
    end

    dmem_bank #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk (clk),
        .adr (bank_adr),
        .we  (bank_we),
        .wd  (bank_wd),
        .rd  (bank_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            load_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (upg_start_i && !upg_done_i) begin
                        state      <= ST_LOAD;
                        load_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (upg_wen_i && load_count != FULL)
                        load_count <= load_count + 1'b1;
                    if (upg_done_i) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Misalign strobes ride the load pipeline so responses stay in order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_rd   <= 1'b0;
            p_mis  <= 1'b0;
            p_size <= SZ_BYTE;
            p_uns  <= 1'b0;
            p_lo   <= 2'b00;
        end else begin
            p_rd   <= cpu_rd;
            p_mis  <= (cpu_wr | cpu_rd) & mis_c;
            p_size <= bus.mem_size;
            p_uns  <= bus.mem_unsigned;
            p_lo   <= bus.addr[1:0];
        end
    end

    always_comb begin
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh  = bank_rd >> {p_lo, 3'b000};
        b   = sh[7:0];
        h   = p_lo[1] ? bank_rd[31:16] : bank_rd[15:0];
        ext = bank_rd;
        case (p_size)
            SZ_BYTE: ext = p_uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: ext = p_uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: ext = bank_rd;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            rvalid_q <= p_rd;
            mis_q    <= p_mis;
            if (p_rd) rdata_q <= p_mis ? 32'b0 : ext;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.misalign = mis_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised scoreboard bench for dmem_ctrl against a byte-array
// reference model of memory contents and loader ownership.
module tb_dmem_ctrl;
    localparam int AW  = 6;
    localparam int NW  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          loading;
    logic [AW:0]   load_count;
    logic          upg_start_i = 1'b0;
    logic          upg_wen_i = 1'b0;
    logic [AW-1:0] upg_adr_i = '0;
    logic [31:0]   upg_dat_i = '0;
    logic          upg_done_i = 1'b1;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(AW)) bus ();

    dmem_ctrl #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .loading     (loading),
        .load_count  (load_count),
        .upg_start_i (upg_start_i),
        .upg_wen_i   (upg_wen_i),
        .upg_adr_i   (upg_adr_i),
        .upg_dat_i   (upg_dat_i),
        .upg_done_i  (upg_done_i)
    );

    typedef struct {
        int          cyc;
        bit          mis;
        bit          rv;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        em;
    logic [7:0]  mref [4*NW];
    bit          m_load = 1'b0;
    int          m_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL resp_missing: nothing seen, required response at cycle %0d", q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.rvalid || bus.misalign) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got rvalid=%0b misalign=%0b at cycle %0d, required none",
                             bus.rvalid, bus.misalign, cyc);
                end else begin
                    em = q.pop_front();
                    if (em.cyc != cyc || em.mis != bus.misalign || em.rv != bus.rvalid ||
                        (em.rv && bus.rdata !== em.data)) begin
                        errors++;
                        $display("FAIL resp: got cyc=%0d rv=%0b mis=%0b rdata=%h, required cyc=%0d rv=%0b mis=%0b rdata=%h",
                                 cyc, bus.rvalid, bus.misalign, bus.rdata,
                                 em.cyc, em.rv, em.mis, em.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_own(input string name);
        check({name, "_loading"}, {31'b0, loading}, {31'b0, m_load});
        check({name, "_count"}, {{(31-AW){1'b0}}, load_count}, m_cnt);
    endtask

    task automatic cpu(input bit rd, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [AW+1:0] a, input logic [31:0] wd);
        bit          mis;
        int          nb;
        logic [31:0] v;
        exp_t        e;
        bus.mem_read     = rd;
        bus.mem_write    = wr;
        bus.mem_size     = sz;
        bus.mem_unsigned = uns;
        bus.addr         = a;
        bus.wdata        = wd;
        if (!m_load && (rd || wr)) begin
            mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
            nb  = 1 << sz;
            e.cyc  = cyc + 2;
            e.mis  = mis;
            e.data = 32'b0;
            if (wr) begin
                e.rv = 1'b0;
                if (mis) q.push_back(e);
                else for (int i = 0; i < nb; i++) mref[int'(a) + i] = wd[8*i +: 8];
            end else begin
                e.rv = 1'b1;
                if (!mis) begin
                    v = 32'b0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = mref[int'(a) + i];
                    if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                    e.data = v;
                end
                q.push_back(e);
            end
        end
        step();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic upg_start(input bit done);
        upg_start_i = 1'b1;
        upg_done_i  = done;
        if (!m_load && !done) begin
            m_load = 1'b1;
            m_cnt  = 0;
        end
        step();
        upg_start_i = 1'b0;
    endtask

    task automatic upg_write(input int adr, input logic [31:0] dat);
        upg_wen_i = 1'b1;
        upg_adr_i = adr[AW-1:0];
        upg_dat_i = dat;
        if (m_load) begin
            for (int i = 0; i < 4; i++) mref[4*(adr % NW) + i] = dat[8*i +: 8];
            if (m_cnt < NW) m_cnt++;
        end
        step();
        upg_wen_i = 1'b0;
    endtask

    task automatic upg_finish();
        upg_done_i = 1'b1;
        m_load = 1'b0;
        step();
    endtask

    initial begin
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_size     = 2'd0;
        bus.mem_unsigned = 1'b0;
        bus.addr         = '0;
        bus.wdata        = '0;

        #1 rst = 1'b1;
        #2;
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'h0);
        check_own("rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();

        // Fill the whole bank via the loader, overrunning to hit saturation.
        upg_start(1'b0);
        check_own("sess1_start");
        for (int i = 0; i < NW + 6; i++) begin
            upg_write(i % NW, $urandom);
            if (i == NW - 1) check_own("sess1_full");
        end
        check_own("sess1_sat");
        cpu(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 32'h0BAD_0BAD);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 32'h0);
        upg_finish();
        check_own("sess1_done");
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 32'h0);

        cpu(1'b0, 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        cpu(1'b0, 1'b1, 2'd0, 1'b0, 8'h13, 32'h0000_0080);
        cpu(1'b1, 1'b0, 2'd0, 1'b0, 8'h13, 32'h0);
        cpu(1'b1, 1'b0, 2'd0, 1'b1, 8'h13, 32'h0);
        cpu(1'b1, 1'b0, 2'd1, 1'b0, 8'h12, 32'h0);
        cpu(1'b1, 1'b0, 2'd1, 1'b1, 8'h12, 32'h0);
        cpu(1'b0, 1'b1, 2'd1, 1'b0, 8'h21, 32'h0000_FFFF);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h20, 32'h0);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h22, 32'h0);
        cpu(1'b1, 1'b0, 2'd3, 1'b1, 8'h24, 32'h0);
        cpu(1'b0, 1'b1, 2'd3, 1'b0, 8'h24, 32'hFFFF_FFFF);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h24, 32'h0);
        repeat (3) step();

        upg_start(1'b0);
        for (int i = 0; i < 4; i++) upg_write(i, i + 1);
        cpu(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 32'h0BAD_0BAD);
        upg_finish();
        check_own("sess2_done");
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h08, 32'h0);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 32'h0);
        repeat (3) step();

        upg_start(1'b0);
        upg_write(5, 32'hA5A5_0005);
        upg_write(6, 32'h5A5A_0006);
        #2 rst = 1'b1;
        m_load = 1'b0;
        m_cnt  = 0;
        #1;
        check_own("rst_midload");
        @(negedge clk) rst = 1'b0;
        upg_done_i = 1'b1;
        step();
        check_own("after_rst");
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h14, 32'h0);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h18, 32'h0);

        upg_start(1'b1);
        check_own("start_and_done");
        cpu(1'b1, 1'b1, 2'd2, 1'b0, 8'h30, 32'h1234_5678);
        cpu(1'b1, 1'b0, 2'd2, 1'b0, 8'h30, 32'h0);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) step();
            else cpu(r[0] | (r == 8), r[1] | (r == 9), 2'($urandom_range(0, 3)),
                     1'($urandom), 8'($urandom), $urandom);
        end

        repeat (4) step();
        check("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
